uart_cmd_parser: RTL and testbench
==================================

Name: uart_cmd_parser

Overview:
- Downstream consumer of the UART byte receiver.
- Assembles received bytes into fixed 5-byte command frames: HEADER, CMD, ADDR, DATA, CHK.
- Validates the checksum and the inter-byte timing, then presents one decoded command per good frame to the register/control logic.
- Bytes received with a stop-bit error are discarded, and the frame in progress is aborted.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- UART_BPS, 115200, line baud rate; used only to size the timeout.
- HEADER, 8'hA5, frame sync byte.
- TIMEOUT_BYTES, 4, maximum gap between bytes inside a frame, in byte times.
- Derived localparam TIMEOUT_CNT = TIMEOUT_BYTES*10*(CLK_FREQ/UART_BPS). Counter width = $clog2(TIMEOUT_CNT).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rx_data  in  8  received byte; valid only while done_flag=1
- done_flag  in  1  one-cycle byte-received strobe from the receiver
- frame_error  in  1  stop-bit error; sampled only when done_flag=1
- pkt_valid  out  1  one-cycle strobe: a good frame was decoded
- pkt_cmd  out  8  CMD field of the last good frame
- pkt_addr  out  8  ADDR field of the last good frame
- pkt_data  out  8  DATA field of the last good frame
- chk_err  out  1  one-cycle strobe: checksum mismatch, frame dropped
- tmo_err  out  1  one-cycle strobe: inter-byte timeout, frame dropped
- fe_abort  out  1  one-cycle strobe: frame_error byte arrived mid-frame, frame dropped
- busy  out  1  high while a frame is partially received (state != S_IDLE)

Behaviour:
- Reset (async, rst_n=0): state=S_IDLE, all outputs 0, internal CMD/ADDR/DATA/checksum/timeout registers 0.
- Byte event: done_flag=1 && frame_error=0. Error byte: done_flag=1 && frame_error=1.
- States: S_IDLE, S_CMD, S_ADDR, S_DATA, S_CHK.
  - S_IDLE: a byte event with rx_data==HEADER goes to S_CMD. Any other byte is silently discarded; no error strobe.
  - S_CMD: a byte event latches CMD and goes to S_ADDR.
  - S_ADDR: a byte event latches ADDR and goes to S_DATA.
  - S_DATA: a byte event latches DATA and goes to S_CHK.
  - S_CHK: a byte event compares rx_data with CMD^ADDR^DATA, then returns to S_IDLE.
    - Match: on the next clock, pkt_valid=1 for one cycle and pkt_cmd/addr/data are updated.
    - Mismatch: on the next clock, chk_err=1 for one cycle and the pkt_* outputs are unchanged.
- HEADER is not included in the checksum.
- Latency: pkt_valid is registered, asserted the cycle after the done_flag of the CHK byte.
- pkt_cmd/addr/data hold their value until the next good frame; they never change on error.
- Error byte:
  - In S_IDLE: ignored, no strobe.
  - In any other state: fe_abort pulses one cycle and the state goes to S_IDLE.
- Timeout counter:
  - Cleared in S_IDLE and on every byte or error byte.
  - Otherwise increments by 1 per clock.
  - When it reaches TIMEOUT_CNT-1 outside S_IDLE: tmo_err pulses one cycle next clock, state goes to S_IDLE, counter clears.
- Simultaneous timeout terminal count and done_flag in the same cycle: the byte wins, it is processed normally and there is no tmo_err.
- At most one of pkt_valid/chk_err/tmo_err/fe_abort is high in any cycle.
- A HEADER value arriving mid-frame is treated as data; there is no resync. Resync happens only through the error/timeout return to S_IDLE.
- Back-to-back frames: a HEADER byte may arrive on any cycle after the CHK byte. No dead time is required, since done_flag strobes are ≥1 byte time apart.
- rst_n asserted mid-frame: immediate return to S_IDLE. No strobes are emitted, and the partial frame is lost.
- busy is combinational from state (state != S_IDLE).

Decomposition:
- Shared package uart_pkg holds:
  - the state enum (S_IDLE..S_CHK, 3-bit encoding);
  - the default HEADER constant;
  - a function computing TIMEOUT_CNT from CLK_FREQ, UART_BPS and byte count;
  - the FRAME_LEN=5 constant.
- Single module; no sub-module. The timeout counter is inline (under 20 lines) and does not justify its own block.

Test Plan:
Bench parameters: CLK_FREQ=1_000_000, UART_BPS=100_000 (byte time 100 clk, TIMEOUT_CNT=400); done_flag driven directly, 100 clk apart.
- Good frame A5,12,34,56,70 (12^34^56=70) -> pkt_valid one cycle after the 5th done_flag; cmd=12, addr=34, data=56; no error strobes; busy low after.
- A5,12,34,56,71 -> chk_err one cycle; pkt_valid stays 0; pkt_* retain the previous values 12/34/56.
- Garbage 00,FF,A4 then a good frame A5,01,02,03,00 -> no strobes for the garbage; pkt_valid with 01/02/03.
- A5,12 then 400-clk silence -> tmo_err exactly 400 clk after the 12 strobe; a following good frame decodes normally. Repeat with the gap at 399 clk -> no tmo_err.
- A5,12,(34 with frame_error=1) -> fe_abort one cycle, state S_IDLE. Separately, frame_error=1 on a byte in S_IDLE -> no strobe.
- rst_n pulse low after A5,12,34 -> busy=0 immediately, no strobes; then A5,AA,BB,CC,DD (AA^BB^CC=DD) -> pkt_valid with AA/BB/CC.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART command-frame parser.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CMD  = 3'd1,
        S_ADDR = 3'd2,
        S_DATA = 3'd3,
        S_CHK  = 3'd4
    } state_t;

    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;
    localparam int         FRAME_LEN      = 5;

    // One UART byte is 10 bit times (start + 8 data + stop).
    function automatic int timeout_cnt(input int clk_freq, input int uart_bps, input int n_bytes);
        return n_bytes * 10 * (clk_freq / uart_bps);
    endfunction

endpackage

// File: rtl/uart_cmd_parser.sv
// Assembles HEADER/CMD/ADDR/DATA/CHK frames from received UART bytes and
// emits one decoded command per good frame, or a single error strobe.
module uart_cmd_parser
    import uart_pkg::*;
#(
    parameter int         CLK_FREQ      = 50_000_000,
    parameter int         UART_BPS      = 115200,
    parameter logic [7:0] HEADER        = HEADER_DEFAULT,
    parameter int         TIMEOUT_BYTES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       done_flag,
    input  logic       frame_error,
    output logic       pkt_valid,
    output logic [7:0] pkt_cmd,
    output logic [7:0] pkt_addr,
    output logic [7:0] pkt_data,
    output logic       chk_err,
    output logic       tmo_err,
    output logic       fe_abort,
    output logic       busy
);

    localparam int TIMEOUT_CNT = timeout_cnt(CLK_FREQ, UART_BPS, TIMEOUT_BYTES);
    localparam int CW          = $clog2(TIMEOUT_CNT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CNT - 1);

    state_t        state, state_nxt;
    logic [7:0]    cmd_q, addr_q, data_q;
    logic [7:0]    cmd_nxt, addr_nxt, data_nxt;
    logic [CW-1:0] cnt_q, cnt_nxt;
    logic [7:0]    pkt_cmd_nxt, pkt_addr_nxt, pkt_data_nxt;
    logic          pkt_valid_nxt, chk_err_nxt, tmo_err_nxt, fe_abort_nxt;
    logic          byte_ev, err_ev, tmo_hit;

    assign byte_ev = done_flag & ~frame_error;
    assign err_ev  = done_flag & frame_error;
    assign tmo_hit = (state != S_IDLE) && (cnt_q == CNT_LAST);
    assign busy    = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cmd_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            cnt_q     <= '0;
            pkt_valid <= 1'b0;
            chk_err   <= 1'b0;
            tmo_err   <= 1'b0;
            fe_abort  <= 1'b0;
            pkt_cmd   <= '0;
            pkt_addr  <= '0;
            pkt_data  <= '0;
        end else begin
            state     <= state_nxt;
            cmd_q     <= cmd_nxt;
            addr_q    <= addr_nxt;
            data_q    <= data_nxt;
            cnt_q     <= cnt_nxt;
            pkt_valid <= pkt_valid_nxt;
            chk_err   <= chk_err_nxt;
            tmo_err   <= tmo_err_nxt;
            fe_abort  <= fe_abort_nxt;
            pkt_cmd   <= pkt_cmd_nxt;
            pkt_addr  <= pkt_addr_nxt;
            pkt_data  <= pkt_data_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cmd_nxt       = cmd_q;
        addr_nxt      = addr_q;
        data_nxt      = data_q;
        pkt_cmd_nxt   = pkt_cmd;
        pkt_addr_nxt  = pkt_addr;
        pkt_data_nxt  = pkt_data;
        pkt_valid_nxt = 1'b0;
        chk_err_nxt   = 1'b0;
        tmo_err_nxt   = 1'b0;
        fe_abort_nxt  = 1'b0;

        // Any received strobe restarts the gap measurement, so a byte
        // landing on the terminal count beats the timeout.
        if (state == S_IDLE || done_flag || tmo_hit) begin
            cnt_nxt = '0;
        end else begin
            cnt_nxt = cnt_q + CW'(1);
        end

        if (state == S_IDLE) begin
            if (byte_ev && rx_data == HEADER) begin
                state_nxt = S_CMD;
            end
        end else if (err_ev) begin
            fe_abort_nxt = 1'b1;
            state_nxt    = S_IDLE;
        end else if (byte_ev) begin
            case (state)
                S_CMD: begin
                    cmd_nxt   = rx_data;
                    state_nxt = S_ADDR;
                end
                S_ADDR: begin
                    addr_nxt  = rx_data;
                    state_nxt = S_DATA;
                end
                S_DATA: begin
                    data_nxt  = rx_data;
                    state_nxt = S_CHK;
                end
                S_CHK: begin
                    if (rx_data == (cmd_q ^ addr_q ^ data_q)) begin
                        pkt_valid_nxt = 1'b1;
                        pkt_cmd_nxt   = cmd_q;
                        pkt_addr_nxt  = addr_q;
                        pkt_data_nxt  = data_q;
                    end else begin
                        chk_err_nxt = 1'b1;
                    end
                    state_nxt = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end else if (tmo_hit) begin
            tmo_err_nxt = 1'b1;
            state_nxt   = S_IDLE;
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: directed frames followed by random
// traffic, compared against a frame-level reference model.
module tb_uart_cmd_parser;

    localparam int         BYTE_GAP = 99;   // done_flag strobes land 100 clk apart
    localparam int         TMO      = 400;
    localparam logic [7:0] HDR      = 8'hA5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       done_flag = 1'b0;
    logic       frame_error = 1'b0;
    logic       pkt_valid, chk_err, tmo_err, fe_abort, busy;
    logic [7:0] pkt_cmd, pkt_addr, pkt_data;

    uart_cmd_parser #(
        .CLK_FREQ(1_000_000), .UART_BPS(100_000), .HEADER(HDR), .TIMEOUT_BYTES(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .done_flag(done_flag),
        .frame_error(frame_error), .pkt_valid(pkt_valid), .pkt_cmd(pkt_cmd),
        .pkt_addr(pkt_addr), .pkt_data(pkt_data), .chk_err(chk_err),
        .tmo_err(tmo_err), .fe_abort(fe_abort), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: bytes of the frame in progress, expected strobes
    // {valid,chk,tmo,fe} for the current cycle, and the last good command.
    logic [7:0]  frame_q[$];
    logic [3:0]  exp_strb;
    logic [23:0] exp_pkt;
    int          since_last;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".strobes"}, {28'd0, pkt_valid, chk_err, tmo_err, fe_abort}, {28'd0, exp_strb});
        check({tag, ".busy"}, {31'd0, busy}, {31'd0, frame_q.size() != 0});
        check({tag, ".pkt"}, {8'd0, pkt_cmd, pkt_addr, pkt_data}, {8'd0, exp_pkt});
    endtask

    function automatic void model_byte(input logic [7:0] b, input logic fe);
        logic [7:0] sum;
        exp_strb = 4'b0000;
        if (fe) begin
            if (frame_q.size() != 0) begin
                exp_strb = 4'b0001;
                frame_q.delete();
            end
        end else if (frame_q.size() == 0) begin
            if (b == HDR) frame_q.push_back(b);
        end else begin
            frame_q.push_back(b);
            if (frame_q.size() == 5) begin
                sum = frame_q[1] ^ frame_q[2] ^ frame_q[3];
                if (frame_q[4] == sum) begin
                    exp_strb = 4'b1000;
                    exp_pkt  = {frame_q[1], frame_q[2], frame_q[3]};
                end else begin
                    exp_strb = 4'b0100;
                end
                frame_q.delete();
            end
        end
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic fe);
        @(negedge clk);
        done_flag   = 1'b1;
        frame_error = fe;
        rx_data     = b;
        @(posedge clk);
        #1;
        model_byte(b, fe);
        since_last = 0;
        check("byte", 32'(b), 32'(rx_data));
        check_outputs("byte");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            done_flag   = 1'b0;
            frame_error = 1'b0;
            rx_data     = 8'($urandom);
            @(posedge clk);
            #1;
            since_last++;
            exp_strb = 4'b0000;
            if (frame_q.size() != 0 && since_last == TMO) begin
                exp_strb = 4'b0010;
                frame_q.delete();
            end
            check_outputs("idle");
        end
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d,
                              input logic [7:0] k);
        send_byte(HDR, 1'b0); idle(BYTE_GAP);
        send_byte(c, 1'b0);   idle(BYTE_GAP);
        send_byte(a, 1'b0);   idle(BYTE_GAP);
        send_byte(d, 1'b0);   idle(BYTE_GAP);
        send_byte(k, 1'b0);   idle(BYTE_GAP);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        frame_q.delete();
        exp_strb = 4'b0000;
        exp_pkt  = 24'h0;
        check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        since_last = 0;
    endtask

    initial begin
        logic [7:0] c, a, d, k;
        int         kind, gap;

        exp_strb   = 4'b0000;
        exp_pkt    = 24'h0;
        since_last = 0;
        #1;
        check_outputs("por");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(5);

        // Good frame, then bad checksum keeps the previous command.
        send_frame(8'h12, 8'h34, 8'h56, 8'h70);
        check("good1.pkt", {8'd0, pkt_cmd, pkt_addr, pkt_data}, 32'h00123456);
        send_frame(8'h12, 8'h34, 8'h56, 8'h71);

        // Garbage in idle is silently dropped, then a clean frame.
        send_byte(8'h00, 1'b0); idle(BYTE_GAP);
        send_byte(8'hFF, 1'b0); idle(BYTE_GAP);
        send_byte(8'hA4, 1'b0); idle(BYTE_GAP);
        send_frame(8'h01, 8'h02, 8'h03, 8'h00);
        check("good2.pkt", {8'd0, pkt_cmd, pkt_addr, pkt_data}, 32'h00010203);

        // Timeout exactly 400 clk after the last byte, then recovery.
        send_byte(HDR, 1'b0); idle(BYTE_GAP);
        send_byte(8'h12, 1'b0); idle(TMO + 20);
        send_frame(8'h12, 8'h34, 8'h56, 8'h70);

        // Gap of 399 clk, and a byte landing on the terminal count itself.
        send_byte(HDR, 1'b0); idle(398);
        send_byte(8'h21, 1'b0); idle(TMO - 1);
        send_byte(8'h43, 1'b0); idle(BYTE_GAP);
        send_byte(8'h65, 1'b0); idle(BYTE_GAP);
        send_byte(8'h21 ^ 8'h43 ^ 8'h65, 1'b0); idle(BYTE_GAP);
        check("edge.pkt", {8'd0, pkt_cmd, pkt_addr, pkt_data}, 32'h00214365);

        // Stop-bit error mid-frame aborts; in idle it is ignored.
        send_byte(HDR, 1'b0); idle(BYTE_GAP);
        send_byte(8'h12, 1'b0); idle(BYTE_GAP);
        send_byte(8'h34, 1'b1); idle(BYTE_GAP);
        send_byte(HDR, 1'b1); idle(BYTE_GAP);

        // Reset mid-frame, then a fresh frame.
        send_byte(HDR, 1'b0); idle(BYTE_GAP);
        send_byte(8'h12, 1'b0); idle(BYTE_GAP);
        send_byte(8'h34, 1'b0); idle(10);
        pulse_reset();
        idle(10);
        send_frame(8'hAA, 8'hBB, 8'hCC, 8'hDD);

        // Mid-frame HEADER is data; back-to-back frames without dead time.
        send_frame(HDR, 8'h00, 8'h00, HDR);
        send_frame(8'h5A, 8'h00, 8'h00, 8'h5A);

        // Random traffic: mixes good, corrupted, aborted and stalled frames.
        for (int f = 0; f < 30; f++) begin
            c = 8'($urandom); a = 8'($urandom); d = 8'($urandom);
            k = c ^ a ^ d;
            kind = $urandom_range(0, 5);
            if (kind == 1) k = k ^ 8'(1 << $urandom_range(0, 7));
            send_byte(kind == 4 ? 8'($urandom) : HDR, 1'b0);
            for (int b = 0; b < 4; b++) begin
                gap = (kind == 3 && b == 1) ? $urandom_range(TMO - 3, TMO + 3)
                                            : $urandom_range(BYTE_GAP, BYTE_GAP + 20);
                idle(gap);
                case (b)
                    0: send_byte(c, 1'b0);
                    1: send_byte(a, kind == 2 && ($urandom_range(0, 1) == 1));
                    2: send_byte(d, 1'b0);
                    default: send_byte(k, 1'b0);
                endcase
            end
            idle($urandom_range(BYTE_GAP, TMO + 10));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
